iso_blank_scheduler: RTL and testbench
======================================

Name: iso_blank_scheduler

Overview:
- Line and frame sequencer for the ISO blanking datapath.
- Counts symbol-clock cycles against a latched video timing configuration.
- Drives the blank mapper's scheduling inputs (sched_blank_en, sched_blank_id, sched_blank_state) and a per-cycle active-video enable for the pixel mapper.
- Decides where BS, START (VBID/Mvid/Maud), BLANK (MSA or dummy) and BE fall on each line, so the blank mapper only executes the sequence.

Parameters:
- H_W, 16, width of horizontal timing fields and counter.
- V_W, 16, width of vertical timing fields and counter.
- BS_LEN, 4, cycles of BS phase (BS BF BF BS).
- BE_LEN, 4, cycles of BE phase (BE BF BF BE).

Ports:
- clk  in  1  symbol clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  1  scheduler enable; rising edge latches config and starts
- cfg_htotal  in  H_W  symbols per line
- cfg_hactive  in  H_W  active symbols per line
- cfg_vtotal  in  V_W  lines per frame
- cfg_vactive  in  V_W  active lines per frame
- td_lane_count  in  2  00=1 lane, 01=2 lanes, 11=4 lanes, 10 illegal
- sched_blank_en  out  1  blank mapper enable
- sched_blank_id  out  1  1=HBlank (active-line blanking), 0=VBlank line
- sched_blank_state  out  2  00 BLANK, 01 BS, 10 START, 11 BE
- sched_active_en  out  1  active video symbol slot
- sched_frame_start  out  1  one-cycle pulse at h=0, v=0
- sched_cfg_err  out  1  sticky config error, cleared on next cfg_en rising edge

Behaviour:
- Reset: all outputs 0; h_cnt=0, v_cnt=0; state IDLE; latched config 0.
- States:
  - IDLE: outputs 0. On cfg_en sampled 1 while previous sample was 0: latch all cfg_* and lane count, then validate.
    - Valid: go to RUN with h_cnt=0, v_cnt=cfg_vactive. Starting in vertical blanking guarantees MSA before the first active line.
    - Invalid: sched_cfg_err=1, stay IDLE.
  - RUN: h_cnt increments each cycle. At h_cnt=htotal-1: h_cnt=0 and v_cnt increments; at v_cnt=vtotal-1 it wraps to 0.
  - cfg_en=0 in RUN: next cycle go to IDLE, counters 0, outputs 0; a mid-line abort is allowed.
- Validity: hactive≥1, vactive≥1, vtotal>vactive, lane code≠10, and htotal ≥ hactive+BS_LEN+START_LEN+BE_LEN+1.
- START_LEN: 12 for 1 lane, 6 for 2 lanes, 3 for 4 lanes.
- Line layout, with active_line = (v_cnt < vactive):
  - h in [0, hactive): active line → sched_active_en=1, blank_en=0. Vblank line → blank_en=1, state=00.
  - h in [hactive, hactive+BS_LEN): state 01.
  - Next START_LEN cycles: state 10.
  - Up to htotal-BE_LEN: state 00.
  - h in [htotal-BE_LEN, htotal): state 11 if the next line is active (v_cnt=vactive-1 is excluded; v_cnt=vtotal-1 is included), else state 00.
  - sched_blank_en=1 for every non-active cycle in RUN.
  - sched_blank_id = active_line.
- Latency: every output is registered from (h_cnt, v_cnt). Output lags the counter by exactly 1 cycle.
- sched_frame_start is asserted with the output corresponding to h=0, v=0.
- Config is re-latched only on a cfg_en rising edge. cfg_* changes during RUN are ignored.
- cfg_en rising and falling are not sampled in the same cycle. A 1-cycle cfg_en pulse starts RUN, then aborts on the next cycle.
- Reset asserted mid-line: immediate return to reset values. After reset, the scheduler needs a new cfg_en rising edge to restart.

Test Plan:
- Config htotal=40, hactive=20, vtotal=4, vactive=2, 4 lanes, cfg_en 0→1 → IDLE→RUN, first outputs are line 2 (id=0): 20 cycles state 00, then 4×01, 3×10, 9×00, 4×00 at h=36..39.
- Same config, line 3 → h=36..39 state 11, id=0; the following line 0 has sched_frame_start=1 for one cycle and sched_active_en=1 for 20 cycles.
- Same config, line 0 → BE at h=36..39 (next line active); line 1 → h=36..39 state 00; blank_id=1 on lines 0 and 1.
- lanes=1, htotal=40, hactive=20 (needs ≥41) → sched_cfg_err=1, all outputs stay 0. Then htotal=41 and a new cfg_en edge → err clears and RUN starts with 12 START cycles.
- Deassert cfg_en at h=22 (mid-BS) → next cycle all outputs 0, counters 0. Re-enable → restarts at v=vactive, h=0.
- Assert rst_n=0 mid-START, then release → all outputs 0 and IDLE; no output activity until a cfg_en rising edge.

Source files
------------

// File: rtl/iso_blank_scheduler.sv
// Line/frame sequencer for the ISO blanking datapath.
// Ports: clk, rst_n, cfg_* timing + td_lane_count in; sched_* out.
module iso_blank_scheduler #(
    parameter int H_W    = 16,
    parameter int V_W    = 16,
    parameter int BS_LEN = 4,
    parameter int BE_LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_en,
    input  logic [H_W-1:0] cfg_htotal,
    input  logic [H_W-1:0] cfg_hactive,
    input  logic [V_W-1:0] cfg_vtotal,
    input  logic [V_W-1:0] cfg_vactive,
    input  logic [1:0]     td_lane_count,
    output logic           sched_blank_en,
    output logic           sched_blank_id,
    output logic [1:0]     sched_blank_state,
    output logic           sched_active_en,
    output logic           sched_frame_start,
    output logic           sched_cfg_err
);

    localparam int HX = H_W + 2;

    localparam logic [1:0] ST_BLANK = 2'b00;
    localparam logic [1:0] ST_BS    = 2'b01;
    localparam logic [1:0] ST_START = 2'b10;
    localparam logic [1:0] ST_BE    = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state;
    logic           en_q;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [H_W-1:0] htotal_q;
    logic [H_W-1:0] hactive_q;
    logic [V_W-1:0] vtotal_q;
    logic [V_W-1:0] vactive_q;
    logic [1:0]     lanes_q;

    // START carries VBID/Mvid/Maud spread over the active lanes.
    function automatic logic [HX-1:0] start_len(
        input logic [1:0] lc
    );
        logic [HX-1:0] r;
        unique case (lc)
            2'b00:   r = HX'(12);
            2'b01:   r = HX'(6);
            default: r = HX'(3);
        endcase
        return r;
    endfunction

    logic          rise;
    logic          cfg_ok;
    logic [HX-1:0] need;

    assign rise = cfg_en & ~en_q;

    // Widened so the minimum-line sum cannot wrap.
    assign need = HX'(cfg_hactive) + HX'(BS_LEN)
                + start_len(td_lane_count)
                + HX'(BE_LEN) + HX'(1);

    assign cfg_ok = (cfg_hactive != '0)
                 && (cfg_vactive != '0)
                 && (cfg_vtotal > cfg_vactive)
                 && (td_lane_count != 2'b10)
                 && (HX'(cfg_htotal) >= need);

    logic [HX-1:0] h_x;
    logic [HX-1:0] ha_x;
    logic [HX-1:0] bs_end;
    logic [HX-1:0] st_end;
    logic [HX-1:0] be_start;
    logic          act_line;
    logic          last_line;
    logic          nxt_act;
    logic          h_last;

    assign h_x      = HX'(h_cnt);
    assign ha_x     = HX'(hactive_q);
    assign bs_end   = ha_x + HX'(BS_LEN);
    assign st_end   = bs_end + start_len(lanes_q);
    assign be_start = HX'(htotal_q) - HX'(BE_LEN);

    assign act_line  = v_cnt < vactive_q;
    assign last_line = v_cnt == (vtotal_q - V_W'(1));
    assign h_last    = h_cnt == (htotal_q - H_W'(1));

    // BE only precedes an active line; frame wrap always lands on one.
    assign nxt_act = last_line
                  || (({1'b0, v_cnt} + (V_W+1)'(1))
                      < {1'b0, vactive_q});

    logic       n_blank_en;
    logic [1:0] n_state;
    logic       n_active;
    logic       n_fs;

    always_comb begin
        n_blank_en = 1'b0;
        n_state    = ST_BLANK;
        n_active   = 1'b0;
        n_fs       = (h_cnt == '0) && (v_cnt == '0);
        if (h_x < ha_x) begin
            if (act_line) begin
                n_active = 1'b1;
            end else begin
                n_blank_en = 1'b1;
            end
        end else begin
            n_blank_en = 1'b1;
            if (h_x < bs_end) begin
                n_state = ST_BS;
            end else if (h_x < st_end) begin
                n_state = ST_START;
            end else if (h_x >= be_start && nxt_act) begin
                n_state = ST_BE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            en_q              <= 1'b0;
            h_cnt             <= '0;
            v_cnt             <= '0;
            htotal_q          <= '0;
            hactive_q         <= '0;
            vtotal_q          <= '0;
            vactive_q         <= '0;
            lanes_q           <= '0;
            sched_blank_en    <= 1'b0;
            sched_blank_id    <= 1'b0;
            sched_blank_state <= ST_BLANK;
            sched_active_en   <= 1'b0;
            sched_frame_start <= 1'b0;
            sched_cfg_err     <= 1'b0;
        end else begin
            en_q <= cfg_en;
            unique case (state)
                IDLE: begin
                    sched_blank_en    <= 1'b0;
                    sched_blank_id    <= 1'b0;
                    sched_blank_state <= ST_BLANK;
                    sched_active_en   <= 1'b0;
                    sched_frame_start <= 1'b0;
                    if (rise) begin
                        htotal_q      <= cfg_htotal;
                        hactive_q     <= cfg_hactive;
                        vtotal_q      <= cfg_vtotal;
                        vactive_q     <= cfg_vactive;
                        lanes_q       <= td_lane_count;
                        sched_cfg_err <= ~cfg_ok;
                        if (cfg_ok) begin
                            state <= RUN;
                            h_cnt <= '0;
                            // Enter in vblank so MSA precedes line 0.
                            v_cnt <= cfg_vactive;
                        end
                    end
                end
                RUN: begin
                    if (!cfg_en) begin
                        state             <= IDLE;
                        h_cnt             <= '0;
                        v_cnt             <= '0;
                        sched_blank_en    <= 1'b0;
                        sched_blank_id    <= 1'b0;
                        sched_blank_state <= ST_BLANK;
                        sched_active_en   <= 1'b0;
                        sched_frame_start <= 1'b0;
                    end else begin
                        sched_blank_en    <= n_blank_en;
                        sched_blank_id    <= act_line;
                        sched_blank_state <= n_state;
                        sched_active_en   <= n_active;
                        sched_frame_start <= n_fs;
                        if (h_last) begin
                            h_cnt <= '0;
                            v_cnt <= last_line ? '0
                                   : v_cnt + V_W'(1);
                        end else begin
                            h_cnt <= h_cnt + H_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iso_blank_scheduler.sv
// Scoreboard bench for iso_blank_scheduler.
// Directed test-plan scenarios followed by randomized configs.
module tb_iso_blank_scheduler;

    localparam int BSL = 4;
    localparam int BEL = 4;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [15:0] cfg_htotal;
    logic [15:0] cfg_hactive;
    logic [15:0] cfg_vtotal;
    logic [15:0] cfg_vactive;
    logic [1:0]  td_lane_count;
    logic        sched_blank_en;
    logic        sched_blank_id;
    logic [1:0]  sched_blank_state;
    logic        sched_active_en;
    logic        sched_frame_start;
    logic        sched_cfg_err;

    iso_blank_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_en            (cfg_en),
        .cfg_htotal        (cfg_htotal),
        .cfg_hactive       (cfg_hactive),
        .cfg_vtotal        (cfg_vtotal),
        .cfg_vactive       (cfg_vactive),
        .td_lane_count     (td_lane_count),
        .sched_blank_en    (sched_blank_en),
        .sched_blank_id    (sched_blank_id),
        .sched_blank_state (sched_blank_state),
        .sched_active_en   (sched_active_en),
        .sched_frame_start (sched_frame_start),
        .sched_cfg_err     (sched_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] exp_q[$];
    logic [6:0] out_v;

    assign out_v = {sched_blank_en, sched_blank_id,
                    sched_blank_state, sched_active_en,
                    sched_frame_start, sched_cfg_err};

    // Reference model: position derived in closed form from
    // the number of RUN cycles since the start edge.
    bit m_run  = 0;
    bit m_prev = 0;
    bit m_err  = 0;
    int m_k    = 0;
    int m_ht, m_ha, m_vt, m_va, m_lc;

    function automatic int start_of(int lc);
        if (lc == 0) return 12;
        if (lc == 1) return 6;
        return 3;
    endfunction

    function automatic bit cfg_valid(int ht, int ha, int vt,
                                     int va, int lc);
        int sl;
        sl = start_of(lc);
        return (ha >= 1) && (va >= 1) && (vt > va)
            && (lc != 2) && (ht >= ha + BSL + sl + BEL + 1);
    endfunction

    function automatic logic [6:0] layout(int k);
        int h, v, sl;
        bit act, nact, en, aen, fs;
        logic [1:0] st;
        h    = k % m_ht;
        v    = (m_va + k / m_ht) % m_vt;
        sl   = start_of(m_lc);
        act  = v < m_va;
        nact = ((v + 1) % m_vt) < m_va;
        fs   = (h == 0) && (v == 0);
        en   = 1'b1;
        aen  = 1'b0;
        st   = 2'd0;
        if (h < m_ha) begin
            if (act) begin
                en  = 1'b0;
                aen = 1'b1;
            end
        end else if (h < m_ha + BSL) begin
            st = 2'd1;
        end else if (h < m_ha + BSL + sl) begin
            st = 2'd2;
        end else if (h >= m_ht - BEL && nact) begin
            st = 2'd3;
        end
        return {en, act, st, aen, fs, m_err};
    endfunction

    function automatic logic [6:0] model_step();
        logic [6:0] o;
        o = '0;
        if (!rst_n) begin
            m_run  = 0;
            m_prev = 0;
            m_err  = 0;
            return '0;
        end
        if (!m_run) begin
            if (cfg_en && !m_prev) begin
                m_ht  = int'(cfg_htotal);
                m_ha  = int'(cfg_hactive);
                m_vt  = int'(cfg_vtotal);
                m_va  = int'(cfg_vactive);
                m_lc  = int'(td_lane_count);
                m_err = !cfg_valid(m_ht, m_ha, m_vt, m_va, m_lc);
                if (!m_err) begin
                    m_run = 1;
                    m_k   = 0;
                end
            end
            o = {6'b0, m_err};
        end else if (!cfg_en) begin
            m_run = 0;
            o     = {6'b0, m_err};
        end else begin
            o   = layout(m_k);
            m_k = m_k + 1;
        end
        m_prev = cfg_en;
        return o;
    endfunction

    // Monitor: one expected entry per clock, checked at negedge.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (out_v !== e) begin
                    errors = errors + 1;
                    $display("FAIL sched cyc=%0d got=%b exp=%b",
                             cyc, out_v, e);
                end
            end
        end
    end

    task automatic step();
        exp_q.push_back(model_step());
        @(negedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic set_cfg(int ht, int ha, int vt, int va,
                           int lc);
        cfg_htotal    = 16'(ht);
        cfg_hactive   = 16'(ha);
        cfg_vtotal    = 16'(vt);
        cfg_vactive   = 16'(va);
        td_lane_count = 2'(lc);
    endtask

    task automatic scramble_cfg();
        cfg_htotal    = 16'($urandom_range(0, 90));
        cfg_hactive   = 16'($urandom_range(0, 90));
        cfg_vtotal    = 16'($urandom_range(0, 8));
        cfg_vactive   = 16'($urandom_range(0, 8));
        td_lane_count = 2'($urandom_range(0, 3));
    endtask

    task automatic check_zero(string tag);
        checks = checks + 1;
        if (out_v !== 7'b0) begin
            errors = errors + 1;
            $display("FAIL %s got=%b exp=%b", tag, out_v, 7'b0);
        end
    endtask

    task automatic do_reset(int n);
        rst_n  = 1'b0;
        cfg_en = 1'b0;
        #1;
        check_zero("async_reset");
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int ht, ha, vt, va, lc, len;
        rst_n  = 1'b0;
        cfg_en = 1'b0;
        set_cfg(40, 20, 4, 2, 3);
        @(negedge clk);
        #1;
        check_zero("reset_state");
        run(3);
        rst_n = 1'b1;
        run(3);

        // Full frame plus a line; cfg changes must be ignored.
        cfg_en = 1'b1;
        step();
        for (int i = 0; i < 200; i++) begin
            if (i > 10) scramble_cfg();
            step();
        end
        cfg_en = 1'b0;
        run(3);

        // Too short for 12 START cycles, then minimum legal.
        set_cfg(40, 20, 4, 2, 0);
        cfg_en = 1'b1;
        run(6);
        cfg_en = 1'b0;
        run(2);
        set_cfg(41, 20, 4, 2, 0);
        cfg_en = 1'b1;
        run(100);
        cfg_en = 1'b0;
        run(2);

        // Abort while h_cnt=22 (mid-BS), then restart.
        set_cfg(40, 20, 4, 2, 3);
        cfg_en = 1'b1;
        run(23);
        cfg_en = 1'b0;
        run(3);
        cfg_en = 1'b1;
        run(45);
        cfg_en = 1'b0;
        run(2);

        // Single-cycle enable pulse.
        cfg_en = 1'b1;
        step();
        cfg_en = 1'b0;
        run(4);

        // Reset mid-START, then idle until a new rising edge.
        cfg_en = 1'b1;
        run(26);
        do_reset(3);
        run(5);
        cfg_en = 1'b1;
        run(60);
        cfg_en = 1'b0;
        run(2);

        for (int it = 0; it < 40; it++) begin
            ht = $urandom_range(14, 70);
            ha = ($urandom_range(0, 9) == 0) ? 0
               : $urandom_range(1, ht - 13);
            vt = $urandom_range(1, 6);
            va = $urandom_range(0, vt);
            lc = $urandom_range(0, 3);
            set_cfg(ht, ha, vt, va, lc);
            cfg_en = 1'b1;
            len = $urandom_range(1, 3 * ht * vt);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) scramble_cfg();
                step();
            end
            if ($urandom_range(0, 7) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cfg_en = 1'b0;
            end
            run($urandom_range(1, 5));
        end

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
